sbox_share_ctrl: RTL and testbench

- Time-multiplexes one shared 4-byte S-box lane between two requesters.
  - Cipher datapath: 128-bit SubBytes, serialized into 4 beats.
  - Key expansion: 32-bit SubWord, 1 beat.
- The lane is an external, purely combinational 4-byte byte-substitution instance, driven via lane_in/lane_out.
- Replaces per-requester 16-byte S-box copies in the area-reduced AES core.

---
 rtl/sbox_share_ctrl.sv | 135 +++++++++++++
 tb/tb_sbox_share_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_ctrl.sv
// Time-multiplexes one external 4-byte S-box lane between a 128-bit state
// requester (4 beats) and a 32-bit key-word requester (1 beat).
module sbox_share_ctrl #(
    parameter bit ARB_MODE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    output logic [127:0] st_out,
    input  logic         wd_valid,
    output logic         wd_ready,
    input  logic [31:0]  wd_in,
    output logic         wd_out_valid,
    output logic [31:0]  wd_out,
    output logic [31:0]  lane_in,
    input  logic [31:0]  lane_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        WD_RUN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q;
    logic [127:0]   st_buf_q;
    logic [127:0]   st_res_q;
    logic [127:0]   st_out_q;
    logic [31:0]    wd_buf_q;
    logic [31:0]    wd_out_q;
    logic           last_grant_q;
    logic           st_out_valid_q;
    logic           wd_out_valid_q;

    logic           both_valid;
    logic           word_wins;
    logic           st_acc;
    logic           wd_acc;

    // Readies only open in IDLE; on a tie the loser's ready is held low.
    always_comb begin
        both_valid = st_valid & wd_valid;
        word_wins  = (ARB_MODE == 1'b0) ? 1'b1 : ~last_grant_q;
        st_ready   = 1'b0;
        wd_ready   = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            st_ready = ~(both_valid & word_wins);
            wd_ready = ~(both_valid & ~word_wins);
        end
        st_acc = st_valid & st_ready;
        wd_acc = wd_valid & wd_ready;
    end

    always_comb begin
        state_d = state_q;
        lane_in = 32'd0;
        case (state_q)
            IDLE: begin
                if (st_acc) begin
                    state_d = ST_RUN;
                end else if (wd_acc) begin
                    state_d = WD_RUN;
                end
            end
            ST_RUN: begin
                lane_in = st_buf_q[{beat_q, 5'b0} +: 32];
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            WD_RUN: begin
                lane_in = wd_buf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= 2'd0;
            last_grant_q   <= 1'b0;
            st_buf_q       <= '0;
            st_res_q       <= '0;
            st_out_q       <= '0;
            wd_buf_q       <= '0;
            wd_out_q       <= '0;
            st_out_valid_q <= 1'b0;
            wd_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            st_out_valid_q <= 1'b0;
            wd_out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st_acc) begin
                        st_buf_q     <= st_in;
                        beat_q       <= 2'd0;
                        last_grant_q <= 1'b0;
                    end else if (wd_acc) begin
                        wd_buf_q     <= wd_in;
                        last_grant_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Final beat bypasses the result register so st_out is complete on this edge.
                    st_res_q[{beat_q, 5'b0} +: 32] <= lane_out;
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        st_out_q       <= {lane_out, st_res_q[95:0]};
                        st_out_valid_q <= 1'b1;
                    end
                end
                WD_RUN: begin
                    wd_out_q       <= lane_out;
                    wd_out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign st_out       = st_out_q;
    assign st_out_valid = st_out_valid_q;
    assign wd_out       = wd_out_q;
    assign wd_out_valid = wd_out_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Scoreboard bench for sbox_share_ctrl: an AES S-box model drives the lane,
// accepts push expected results, completion pulses pop and compare them.
module tb_sbox_share_ctrl;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        int idx;
        idx = int'(x);
        t = SBOX << (8 * idx);
        return t[2047:2040];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(w[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(s[8*i +: 8]);
        return r;
    endfunction

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_valid = 1'b0;
    logic         wd_valid = 1'b0;
    logic [127:0] st_in = '0;
    logic [31:0]  wd_in = '0;

    logic         st_ready, st_out_valid, wd_ready, wd_out_valid, busy;
    logic [127:0] st_out;
    logic [31:0]  wd_out, lane_in, lane_out;

    logic         st_ready_f, st_out_valid_f, wd_ready_f, wd_out_valid_f, busy_f;
    logic [127:0] st_out_f;
    logic [31:0]  wd_out_f, lane_in_f, lane_out_f;

    always #5 clk = ~clk;

    always_comb lane_out   = sub_word(lane_in);
    always_comb lane_out_f = sub_word(lane_in_f);

    sbox_share_ctrl #(.ARB_MODE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
        .st_out_valid(st_out_valid), .st_out(st_out),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_in(wd_in),
        .wd_out_valid(wd_out_valid), .wd_out(wd_out),
        .lane_in(lane_in), .lane_out(lane_out), .busy(busy));

    sbox_share_ctrl #(.ARB_MODE(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready_f), .st_in(st_in),
        .st_out_valid(st_out_valid_f), .st_out(st_out_f),
        .wd_valid(wd_valid), .wd_ready(wd_ready_f), .wd_in(wd_in),
        .wd_out_valid(wd_out_valid_f), .wd_out(wd_out_f),
        .lane_in(lane_in_f), .lane_out(lane_out_f), .busy(busy_f));

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t         st_q[$];
    exp_t         wd_q[$];
    exp_t         mon_e;
    logic [127:0] st_hold;
    logic [31:0]  wd_hold;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            st_q.delete();
            wd_q.delete();
            st_hold = '0;
            wd_hold = '0;
        end else begin
            if (st_valid && wd_valid) begin
                tests++;
                if (st_ready && wd_ready) begin
                    fails++;
                    $display("FAIL ready_excl st_ready=%b wd_ready=%b required not both", st_ready, wd_ready);
                end
            end
            tests++;
            if (st_out_valid) begin
                if (st_q.size() == 0) begin
                    fails++;
                    $display("FAIL st_spurious st_out_valid=1 required 0 (no job pending)");
                end else begin
                    mon_e = st_q.pop_front();
                    if (st_out !== mon_e.data || cyc - mon_e.acc != 4) begin
                        fails++;
                        $display("FAIL st_result got=%h lat=%0d required=%h lat=4", st_out, cyc - mon_e.acc, mon_e.data);
                    end
                    st_hold = mon_e.data;
                end
            end else if (st_out !== st_hold) begin
                fails++;
                $display("FAIL st_hold got=%h required=%h", st_out, st_hold);
            end
            tests++;
            if (wd_out_valid) begin
                if (wd_q.size() == 0) begin
                    fails++;
                    $display("FAIL wd_spurious wd_out_valid=1 required 0 (no job pending)");
                end else begin
                    mon_e = wd_q.pop_front();
                    if (wd_out !== mon_e.data[31:0] || cyc - mon_e.acc != 1) begin
                        fails++;
                        $display("FAIL wd_result got=%h lat=%0d required=%h lat=1", wd_out, cyc - mon_e.acc, mon_e.data[31:0]);
                    end
                    wd_hold = mon_e.data[31:0];
                end
            end else if (wd_out !== wd_hold) begin
                fails++;
                $display("FAIL wd_hold got=%h required=%h", wd_out, wd_hold);
            end
            if (st_valid && st_ready) begin
                mon_e.data = sub_state(st_in);
                mon_e.acc  = cyc + 1;
                st_q.push_back(mon_e);
            end
            if (wd_valid && wd_ready) begin
                mon_e.data = {96'd0, sub_word(wd_in)};
                mon_e.acc  = cyc + 1;
                wd_q.push_back(mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        st_valid = 1'b0;
        wd_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st_valid = 1'b1;
        wd_valid = 1'b1;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        @(negedge clk);
        tests++;
        if (st_ready !== 1'b0 || wd_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl st_ready=%b wd_ready=%b busy=%b required 0 0 0", st_ready, wd_ready, busy);
        end
        tests++;
        if (st_out !== 128'd0 || wd_out !== 32'd0 || lane_in !== 32'd0 || st_out_valid !== 1'b0 || wd_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_data st_out=%h wd_out=%h lane_in=%h required all zero", st_out, wd_out, lane_in);
        end
        step();
        st_valid = 1'b0;
        wd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (st_ready !== 1'b1 || wd_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ready st_ready=%b wd_ready=%b required 1 1", st_ready, wd_ready);
        end
    endtask

    task automatic test_single_state();
        bit ok = 1'b0;
        st_in = 128'h00112233445566778899aabbccddeeff;
        st_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_ready) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL st_accept ready=0 required 1 within 10 cycles"); end
        step();
        st_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests++;
            if (busy !== (k <= 4) || st_out_valid !== (k == 5)) begin
                fails++;
                $display("FAIL st_timing k=%0d busy=%b vld=%b required %b %b", k, busy, st_out_valid, k <= 4, k == 5);
            end
            if (k <= 4) begin
                tests++;
                if (lane_in !== st_in[32*(k-1) +: 32]) begin
                    fails++;
                    $display("FAIL st_lane beat=%0d got=%h required=%h", k - 1, lane_in, st_in[32*(k-1) +: 32]);
                end
            end
        end
        tests++;
        if (st_out !== 128'h638293c31bfc33f5c4eeacea4bc12816) begin
            fails++;
            $display("FAIL st_vector got=%h required=638293c31bfc33f5c4eeacea4bc12816", st_out);
        end
    endtask

    task automatic test_single_word();
        bit ok = 1'b0;
        wd_in = 32'hcf4f3c09;
        wd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wd_ready) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL wd_accept ready=0 required 1 within 10 cycles"); end
        step();
        wd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || lane_in !== 32'hcf4f3c09 || wd_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL wd_run busy=%b lane_in=%h vld=%b required 1 cf4f3c09 0", busy, lane_in, wd_out_valid);
        end
        @(negedge clk);
        tests++;
        if (wd_out_valid !== 1'b1 || wd_out !== 32'h8a84eb01 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wd_vector vld=%b wd_out=%h busy=%b required 1 8a84eb01 0", wd_out_valid, wd_out, busy);
        end
    endtask

    task automatic test_word_wait();
        bit ok = 1'b0;
        int acc = 0;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        st_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_ready) begin ok = 1'b1; acc = cyc + 1; break; end
        end
        step();
        st_valid = 1'b0;
        wd_in = $urandom;
        wd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wd_ready) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok || cyc + 1 - acc != 5) begin
            fails++;
            $display("FAIL word_wait accept_offset=%0d ok=%b required offset 5", cyc + 1 - acc, ok);
        end
        step();
        wd_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_arb_rr();
        int grants[4];
        int n = 0;
        do_reset();
        st_in = {$urandom, $urandom, $urandom, $urandom};
        wd_in = $urandom;
        st_valid = 1'b1;
        wd_valid = 1'b1;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            if (wd_ready) begin grants[n] = 1; n++; end
            else if (st_ready) begin grants[n] = 0; n++; end
        end
        step();
        st_valid = 1'b0;
        wd_valid = 1'b0;
        tests++;
        if (n != 4) begin fails++; $display("FAIL rr_count got=%0d required=4", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (grants[i] != ((i % 2 == 0) ? 1 : 0)) begin
                fails++;
                $display("FAIL rr_order idx=%0d got=%0d required=%0d (1=word)", i, grants[i], (i % 2 == 0) ? 1 : 0);
            end
        end
        repeat (6) step();
    endtask

    task automatic test_arb_fixed();
        bit st_seen = 1'b0;
        int pulses = 0;
        do_reset();
        wd_in = $urandom;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        st_valid = 1'b1;
        wd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_ready_f) st_seen = 1'b1;
            if (wd_out_valid_f) begin
                pulses++;
                tests++;
                if (wd_out_f !== sub_word(wd_in)) begin
                    fails++;
                    $display("FAIL fixed_wd got=%h required=%h", wd_out_f, sub_word(wd_in));
                end
            end
        end
        step();
        st_valid = 1'b0;
        wd_valid = 1'b0;
        tests++;
        if (st_seen) begin fails++; $display("FAIL fixed_tie st_ready=1 required 0 under tie"); end
        tests++;
        if (pulses != 4) begin fails++; $display("FAIL fixed_count got=%0d required=4", pulses); end
        repeat (6) step();
    endtask

    task automatic test_reset_midjob();
        bit seen = 1'b0;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        st_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_ready) break;
        end
        step();
        st_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || st_out_valid !== 1'b0 || st_out !== 128'd0 || lane_in !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset busy=%b vld=%b st_out=%h lane_in=%h required 0", busy, st_out_valid, st_out, lane_in);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (st_out_valid) seen = 1'b1;
        end
        tests++;
        if (seen) begin fails++; $display("FAIL mid_reset_pulse st_out_valid=1 required 0"); end
        st_in = 128'd0;
        st_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_ready) break;
        end
        step();
        st_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (st_out_valid !== 1'b1 || st_out !== {16{8'h63}}) begin
            fails++;
            $display("FAIL zero_state vld=%b got=%h required 1 all-63", st_out_valid, st_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d[3];
        int acc[3];
        for (int j = 0; j < 3; j++) d[j] = {$urandom, $urandom, $urandom, $urandom};
        step();
        st_in = d[0];
        st_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            acc[j] = -100;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (st_ready) begin acc[j] = cyc + 1; break; end
            end
            step();
            if (j < 2) st_in = d[j+1];
            else st_valid = 1'b0;
        end
        for (int j = 1; j < 3; j++) begin
            tests++;
            if (acc[j] - acc[j-1] != 5) begin
                fails++;
                $display("FAIL b2b_spacing job=%0d got=%0d required=5", j, acc[j] - acc[j-1]);
            end
        end
        repeat (8) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_state();
        repeat (2) step();
        test_single_word();
        repeat (2) step();
        test_word_wait();
        test_arb_rr();
        test_arb_fixed();
        test_reset_midjob();
        test_back_to_back();
        tests++;
        if (st_q.size() != 0 || wd_q.size() != 0) begin
            fails++;
            $display("FAIL drain st_pending=%0d wd_pending=%0d required 0 0", st_q.size(), wd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
